// File: rtl/alu_pkg.sv
// Shared encodings for the arbitrated ALU: ALUControl codes and the controller state.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ALU.sv
// Combinational ALU: add/sub/and/or/unsigned set-less-than plus a Zero flag.
module ALU #(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       ctrl,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    import alu_pkg::*;

    // Unassigned codes fall through to a zero result, which raises Zero.
    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD: result = srca + srcb;
            ALU_SUB: result = srca - srcb;
            ALU_AND: result = srca & srcb;
            ALU_OR:  result = srca | srcb;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, (srca < srcb)};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU; one operation in flight at a time.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_srca,
    input  logic [WIDTH-1:0] req0_srcb,
    input  logic [2:0]       req0_ctrl,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_srca,
    input  logic [WIDTH-1:0] req1_srcb,
    input  logic [2:0]       req1_ctrl,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    input  logic             rsp_ready,
    output logic             busy,
    output logic [15:0]      op_count
);
    import alu_pkg::*;

    state_t           state;
    logic             last_id;
    logic             grant0;
    logic             grant1;
    logic             hs0;
    logic             hs1;
    logic [WIDTH-1:0] srca_p0;
    logic [WIDTH-1:0] srcb_p0;
    logic [2:0]       ctrl_p0;
    logic             id_p0;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    // last_id names the requester granted most recently; the other one wins a tie.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_id);
        grant1 = req1_valid & (~req0_valid | ~last_id);
    end

    assign req0_ready = (state == IDLE) & grant0 & ~reset;
    assign req1_ready = (state == IDLE) & grant1 & ~reset;
    assign hs0        = req0_valid & req0_ready;
    assign hs1        = req1_valid & req1_ready;

    // Stage p0: operands captured on the accepting handshake
    always_ff @(posedge clk) begin
        if (hs0 | hs1) begin
            srca_p0 <= hs1 ? req1_srca : req0_srca;
            srcb_p0 <= hs1 ? req1_srcb : req0_srcb;
            ctrl_p0 <= hs1 ? req1_ctrl : req0_ctrl;
            id_p0   <= hs1;
        end
    end

    ALU #(
        .WIDTH (WIDTH)
    ) u_alu (
        .ctrl   (ctrl_p0),
        .srca   (srca_p0),
        .srcb   (srcb_p0),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Stage p1: ALU result registered into the held response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_id    <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            busy       <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs0 | hs1) begin
                        last_id <= hs1;
                        busy    <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_id     <= id_p0;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: latency, round-robin, backpressure, wrap and reset cases.
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid;
    logic [31:0] req0_srca;
    logic [31:0] req0_srcb;
    logic [2:0]  req0_ctrl;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_srca;
    logic [31:0] req1_srcb;
    logic [2:0]  req1_ctrl;
    logic        req1_ready;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_ready;
    logic        busy;
    logic [15:0] op_count;

    int n_checks;
    int n_errors;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_srca  (req0_srca),
        .req0_srcb  (req0_srcb),
        .req0_ctrl  (req0_ctrl),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_srca  (req1_srca),
        .req1_srcb  (req1_srcb),
        .req1_ctrl  (req1_ctrl),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_ready  (rsp_ready),
        .busy       (busy),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request from a single requester and returns at a falling edge with the response held.
    task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        int n;
        rsp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_srca = a; req1_srcb = b; req1_ctrl = c;
        end else begin
            req0_valid = 1'b1; req0_srca = a; req0_srcb = b; req0_ctrl = c;
        end
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) begin
            n_checks++; n_errors++;
            $display("FAIL run_op_ready_timeout: id %0d never granted", id);
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk); n++;
        end
        if (n >= 20) begin
            n_checks++; n_errors++;
            $display("FAIL run_op_rsp_timeout: rsp_valid never rose for id %0d", id);
        end
    endtask

    task automatic test_reset;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_checks++; if (req0_ready !== 1'b0) begin n_errors++; $display("FAIL reset_req0_ready: got %b want 0", req0_ready); end
        n_checks++; if (req1_ready !== 1'b0) begin n_errors++; $display("FAIL reset_req1_ready: got %b want 0", req1_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (op_count !== 16'd0) begin n_errors++; $display("FAIL reset_op_count: got %h want 0", op_count); end
        n_checks++; if ({rsp_id, rsp_zero, rsp_result} !== 34'd0) begin n_errors++; $display("FAIL reset_rsp_fields: id %b zero %b result %h want all 0", rsp_id, rsp_zero, rsp_result); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_op;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_srca = 32'd5; req0_srcb = 32'd7; req0_ctrl = 3'b000;
        #1;
        n_checks++; if (req0_ready !== 1'b1) begin n_errors++; $display("FAIL single_ready: got %b want 1", req0_ready); end
        @(negedge clk);
        req0_valid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL single_early_valid: got %b want 0", rsp_valid); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy_exec: got %b want 1", busy); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
        n_checks++; if (rsp_result !== 32'd12) begin n_errors++; $display("FAIL single_result: got %h want %h", rsp_result, 32'd12); end
        n_checks++; if (rsp_zero !== 1'b0) begin n_errors++; $display("FAIL single_zero: got %b want 0", rsp_zero); end
        n_checks++; if (rsp_id !== 1'b0) begin n_errors++; $display("FAIL single_id: got %b want 0", rsp_id); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL single_valid_drop: got %b want 0", rsp_valid); end
        n_checks++; if (op_count !== 16'd1) begin n_errors++; $display("FAIL single_op_count: got %0d want 1", op_count); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single_busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_contention;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_srca = 32'd9; req0_srcb = 32'd9; req0_ctrl = 3'b001;
        req1_valid = 1'b1; req1_srca = 32'd3; req1_srcb = 32'd4; req1_ctrl = 3'b101;
        #1;
        n_checks++; if ({req0_ready, req1_ready} !== 2'b10) begin n_errors++; $display("FAIL cont_first_grant: got r0 %b r1 %b want r0 1 r1 0", req0_ready, req1_ready); end
        @(negedge clk);
        req0_valid = 1'b0;
        n_checks++; if (req1_ready !== 1'b0) begin n_errors++; $display("FAIL cont_r1_exec_ready: got %b want 0", req1_ready); end
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== {1'b1, 1'b0, 1'b1, 32'd0}) begin n_errors++; $display("FAIL cont_rsp0: valid %b id %b zero %b result %h want 1 0 1 0", rsp_valid, rsp_id, rsp_zero, rsp_result); end
        @(negedge clk);
        #1;
        n_checks++; if (req1_ready !== 1'b1) begin n_errors++; $display("FAIL cont_r1_grant: got %b want 1", req1_ready); end
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== {1'b1, 1'b1, 1'b0, 32'd1}) begin n_errors++; $display("FAIL cont_rsp1: valid %b id %b zero %b result %h want 1 1 0 1", rsp_valid, rsp_id, rsp_zero, rsp_result); end
        @(negedge clk);
        n_checks++; if (op_count !== 16'd2) begin n_errors++; $display("FAIL cont_op_count: got %0d want 2", op_count); end
    endtask

    task automatic test_backpressure;
        rsp_ready  = 1'b0;
        req0_valid = 1'b1; req0_srca = 32'd1; req0_srcb = 32'd2; req0_ctrl = 3'b000;
        #1;
        n_checks++; if (req0_ready !== 1'b1) begin n_errors++; $display("FAIL bp_r0_ready: got %b want 1", req0_ready); end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_srca = 32'd10; req1_srcb = 32'd12; req1_ctrl = 3'b011;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_result, req1_ready} !== {1'b1, 1'b0, 32'd3, 1'b0}) begin
                n_errors++;
                $display("FAIL bp_hold_%0d: valid %b id %b result %h r1_ready %b want 1 0 3 0", i, rsp_valid, rsp_id, rsp_result, req1_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if ({rsp_valid, req1_ready} !== 2'b01) begin n_errors++; $display("FAIL bp_release: valid %b r1_ready %b want 0 1", rsp_valid, req1_ready); end
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 32'd14}) begin n_errors++; $display("FAIL bp_rsp1: valid %b id %b result %h want 1 1 e", rsp_valid, rsp_id, rsp_result); end
        @(negedge clk);
        n_checks++; if (op_count !== 16'd4) begin n_errors++; $display("FAIL bp_op_count: got %0d want 4", op_count); end
    endtask

    task automatic test_wrap_illegal;
        run_op(1'b0, 32'd0, 32'd1, 3'b001);
        n_checks++; if ({rsp_zero, rsp_result} !== {1'b0, 32'hFFFF_FFFF}) begin n_errors++; $display("FAIL wrap_sub: zero %b result %h want 0 ffffffff", rsp_zero, rsp_result); end
        @(negedge clk);
        run_op(1'b1, 32'd5, 32'd6, 3'b111);
        n_checks++; if ({rsp_zero, rsp_result} !== {1'b1, 32'd0}) begin n_errors++; $display("FAIL illegal_111: zero %b result %h want 1 0", rsp_zero, rsp_result); end
        @(negedge clk);
        run_op(1'b0, 32'hF0, 32'h0F, 3'b100);
        n_checks++; if ({rsp_zero, rsp_result} !== {1'b1, 32'd0}) begin n_errors++; $display("FAIL illegal_100: zero %b result %h want 1 0", rsp_zero, rsp_result); end
        @(negedge clk);
        run_op(1'b1, 32'hF0, 32'h3C, 3'b010);
        n_checks++; if ({rsp_zero, rsp_result} !== {1'b0, 32'h30}) begin n_errors++; $display("FAIL and_op: zero %b result %h want 0 30", rsp_zero, rsp_result); end
        @(negedge clk);
        n_checks++; if (op_count !== 16'd8) begin n_errors++; $display("FAIL wrap_pre_count: got %0d want 8", op_count); end
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        #1;
        n_checks++; if (op_count !== 16'hFFFF) begin n_errors++; $display("FAIL wrap_preset: got %h want ffff", op_count); end
        @(negedge clk);
        run_op(1'b0, 32'd1, 32'd1, 3'b000);
        n_checks++; if (rsp_result !== 32'd2) begin n_errors++; $display("FAIL wrap_last_result: got %h want 2", rsp_result); end
        @(negedge clk);
        n_checks++; if (op_count !== 16'h0000) begin n_errors++; $display("FAIL wrap_count: got %h want 0000", op_count); end
    endtask

    task automatic test_reset_in_exec;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_srca = 32'd20; req0_srcb = 32'd22; req0_ctrl = 3'b000;
        @(negedge clk);
        req0_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rexec_busy_before: got %b want 1", busy); end
        reset = 1'b1;
        #1;
        n_checks++; if ({busy, rsp_valid} !== 2'b00) begin n_errors++; $display("FAIL rexec_async: busy %b valid %b want 0 0", busy, rsp_valid); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if ({rsp_valid, busy} !== 2'b00) begin n_errors++; $display("FAIL rexec_no_rsp_%0d: valid %b busy %b want 0 0", i, rsp_valid, busy); end
            @(negedge clk);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_checks++; if ({req0_ready, req1_ready} !== 2'b10) begin n_errors++; $display("FAIL rexec_grant: r0 %b r1 %b want 1 0", req0_ready, req1_ready); end
        n_checks++; if (op_count !== 16'd0) begin n_errors++; $display("FAIL rexec_op_count: got %0d want 0", op_count); end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        rsp_ready  = 1'b0;
        req0_valid = 1'b0; req0_srca = '0; req0_srcb = '0; req0_ctrl = '0;
        req1_valid = 1'b0; req1_srca = '0; req1_srcb = '0; req1_ctrl = '0;
        @(negedge clk);
        @(negedge clk);
        test_reset;
        test_single_op;
        test_contention;
        test_backpressure;
        test_wrap_illegal;
        test_reset_in_exec;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
